// File: rtl/hamming_seq_ctrl.sv
// Serialises chunked x/y word pairs into a bit-serial Hamming accumulator and returns the distance.
// Define HAMMING_SEQ_THRESH_EN to add the thresh input and registered res_match output.
module hamming_seq_ctrl #(
  parameter int unsigned N     = 1600,
  parameter int unsigned CHUNK = 32,
  parameter int unsigned OW    = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CHUNK-1:0] in_x,
  input  logic [CHUNK-1:0] in_y,
`ifdef HAMMING_SEQ_THRESH_EN
  input  logic [OW-1:0]    thresh,
  output logic             res_match,
`endif
  output logic             acc_rst,
  output logic             acc_x,
  output logic             acc_y,
  input  logic [OW-1:0]    acc_o,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [OW-1:0]    res_data,
  output logic             busy
);

  localparam int unsigned CW         = $clog2(CHUNK + 1);
  localparam int unsigned FirstChunk = (CHUNK < N) ? CHUNK : N;

  typedef enum logic [1:0] {StIdle, StRun, StCapture, StOut} state_e;

  state_e           state;
  logic [CHUNK-1:0] xs;
  logic [CHUNK-1:0] ys;
  logic [CW-1:0]    chunk_left;
  logic [OW-1:0]    bits_left;
  logic [OW-1:0]    rest;
  logic [CW-1:0]    next_chunk;
  logic             issue;
  logic             take;

  always_comb begin
    issue = (state == StRun) && (chunk_left != '0);
    // Bits of the job not yet held in the shift registers.
    rest  = bits_left - OW'(chunk_left);
    if (32'(rest) >= CHUNK) begin
      next_chunk = CW'(CHUNK);
    end else begin
      next_chunk = CW'(rest);
    end
    unique case (state)
      StIdle:  in_ready = 1'b1;
      StRun:   in_ready = (chunk_left <= CW'(1)) && (rest != '0);
      default: in_ready = 1'b0;
    endcase
    take    = in_valid && in_ready;
    acc_rst = (state == StIdle);
    acc_x   = issue && xs[0];
    acc_y   = issue && ys[0];
    busy    = (state != StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= StIdle;
      xs         <= '0;
      ys         <= '0;
      chunk_left <= '0;
      bits_left  <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
`ifdef HAMMING_SEQ_THRESH_EN
      res_match  <= 1'b0;
`endif
    end else begin
      unique case (state)
        StIdle: begin
          if (take) begin
            xs         <= in_x;
            ys         <= in_y;
            chunk_left <= CW'(FirstChunk);
            bits_left  <= OW'(N);
            state      <= StRun;
          end
        end
        StRun: begin
          // A reload only happens when the current chunk is on its last bit or already empty.
          if (take) begin
            xs         <= in_x;
            ys         <= in_y;
            chunk_left <= next_chunk;
            bits_left  <= issue ? bits_left - OW'(1) : bits_left;
          end else if (issue) begin
            xs         <= xs >> 1;
            ys         <= ys >> 1;
            chunk_left <= chunk_left - CW'(1);
            bits_left  <= bits_left - OW'(1);
          end
          if (issue && (bits_left == OW'(1))) begin
            state <= StCapture;
          end
        end
        StCapture: begin
          res_data  <= acc_o;
          res_valid <= 1'b1;
`ifdef HAMMING_SEQ_THRESH_EN
          res_match <= (acc_o <= thresh);
`endif
          state     <= StOut;
        end
        StOut: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_hamming_seq_ctrl.sv
// Bench for hamming_seq_ctrl: accumulator model, stream-level expectation model, directed jobs.
module tb_hamming_seq_ctrl;

  localparam int N     = 1600;
  localparam int CHUNK = 32;
  localparam int OW    = 11;
  localparam int NC    = 50;
  localparam int NB    = 40;
  localparam int OWB   = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic in_valid, in_ready, acc_rst, acc_x, acc_y, res_valid, res_ready, busy;
  logic [CHUNK-1:0] in_x, in_y;
  logic [OW-1:0] acc_o, acc_cnt, res_data;

  logic in_valid_b, in_ready_b, acc_rst_b, acc_x_b, acc_y_b, res_valid_b, res_ready_b, busy_b;
  logic [CHUNK-1:0] in_x_b, in_y_b;
  logic [OWB-1:0] acc_o_b, acc_cnt_b, res_data_b;

`ifdef HAMMING_SEQ_THRESH_EN
  logic [OW-1:0]  thresh;
  logic           res_match;
  logic [OWB-1:0] thresh_b;
  logic           res_match_b;
`endif

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  hamming_seq_ctrl #(.N(N), .CHUNK(CHUNK), .OW(OW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
`ifdef HAMMING_SEQ_THRESH_EN
    .thresh(thresh), .res_match(res_match),
`endif
    .acc_rst(acc_rst), .acc_x(acc_x), .acc_y(acc_y), .acc_o(acc_o), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .busy(busy)
  );

  hamming_seq_ctrl #(.N(NB), .CHUNK(CHUNK), .OW(OWB)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b), .in_x(in_x_b),
    .in_y(in_y_b),
`ifdef HAMMING_SEQ_THRESH_EN
    .thresh(thresh_b), .res_match(res_match_b),
`endif
    .acc_rst(acc_rst_b), .acc_x(acc_x_b), .acc_y(acc_y_b), .acc_o(acc_o_b),
    .res_valid(res_valid_b), .res_ready(res_ready_b), .res_data(res_data_b), .busy(busy_b)
  );

  // Bit-serial accumulators: count of unequal pairs, cleared by RST; output is the next count.
  always @(posedge clk or posedge rst) begin
    if (rst || acc_rst) acc_cnt <= '0;
    else acc_cnt <= acc_cnt + OW'(acc_x ^ acc_y);
  end
  assign acc_o = acc_rst ? '0 : acc_cnt + OW'(acc_x ^ acc_y);

  always @(posedge clk or posedge rst) begin
    if (rst || acc_rst_b) acc_cnt_b <= '0;
    else acc_cnt_b <= acc_cnt_b + OWB'(acc_x_b ^ acc_y_b);
  end
  assign acc_o_b = acc_rst_b ? '0 : acc_cnt_b + OWB'(acc_x_b ^ acc_y_b);

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Stream model: accepted bits queue up and leave one per cycle; starved cycles carry 0/0.
  logic [1:0] bq[$];
  bit in_job = 1'b0;
  int job_left = 0;
  int exp_dist = 0;
  int last_issue = -10;

  always @(negedge clk) begin
    logic [1:0] expb;
    bit exp_rv;
    int n;
    if (rst) begin
      bq.delete();
      in_job = 1'b0;
      job_left = 0;
      exp_dist = 0;
      last_issue = -10;
      check("rst_acc_rst", acc_rst, 1);
      check("rst_res_valid", res_valid, 0);
    end else begin
      expb = 2'b00;
      if (bq.size() > 0) begin
        expb = bq.pop_front();
        last_issue = cyc;
      end
      check("acc_bits", {acc_x, acc_y}, expb);
      check("acc_rst", acc_rst, !in_job);
      check("busy", busy, in_job);
      if (!in_job) check("in_ready_idle", in_ready, 1);
      else if (job_left == 0) check("in_ready_done", in_ready, 0);
      exp_rv = in_job && (job_left == 0) && (bq.size() == 0) && (cyc >= last_issue + 2);
      check("res_valid", res_valid, exp_rv);
      if (res_valid) check("res_data", res_data, exp_dist);
      if (in_valid && in_ready) begin
        if (!in_job) begin
          in_job = 1'b1;
          job_left = N;
          exp_dist = 0;
        end
        n = (job_left < CHUNK) ? job_left : CHUNK;
        for (int i = 0; i < n; i++) begin
          bq.push_back({in_x[i], in_y[i]});
          exp_dist += int'(in_x[i] ^ in_y[i]);
        end
        job_left -= n;
      end
      if (res_valid && res_ready) in_job = 1'b0;
    end
  end

  function automatic void pattern(input int t, input int k, output logic [31:0] x,
                                  output logic [31:0] y);
    case (t)
      1: begin x = 32'hFFFF_FFFF; y = 32'h0000_0000; end
      2: begin x = 32'hA5A5_A5A5; y = 32'hA5A5_A5A5; end
      3: begin x = 32'hAAAA_AAAA; y = 32'h5555_5555; end
      default: begin
        x = 32'hFFFF_0000 ^ (32'd1 << (k % 32));
        y = 32'hFFFF_0000;
      end
    endcase
  endfunction

  task automatic send_chunk(input logic [31:0] x, input logic [31:0] y, output int hs);
    int w;
    in_valid = 1'b1;
    in_x = x;
    in_y = y;
    w = 0;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      w++;
      if (w > 200) begin
        check("in_ready_timeout", 0, 1);
        break;
      end
    end
    hs = cyc;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_ready();
    int w = 0;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      w++;
      if (w > 200) begin
        check("ready_wait_timeout", 0, 1);
        break;
      end
    end
  endtask

  task automatic wait_result(input int hs, input int exp_lat, input int exp_data, input string tag);
    int w = 0;
    while (1) begin
      @(negedge clk);
      if (res_valid) break;
      w++;
      if (w > N + 100) begin
        check({tag, "_timeout"}, 0, 1);
        break;
      end
    end
    check({tag, "_latency"}, cyc - hs, exp_lat);
    check({tag, "_data"}, res_data, exp_data);
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input int t, input int stall_at, input int exp_lat, input int exp_data,
                         input string tag);
    logic [31:0] x, y;
    int hs, h0, hp;
    h0 = 0;
    hp = 0;
    for (int k = 0; k < NC; k++) begin
      if (k == stall_at) begin
        wait_ready();
        repeat (5) @(posedge clk);
        #1;
      end
      pattern(t, k, x, y);
      send_chunk(x, y, hs);
      if (k == 0) h0 = hs;
      else if (k != stall_at) check({tag, "_chunk_gap"}, hs - hp, CHUNK);
      hp = hs;
    end
    wait_result(h0, exp_lat, exp_data, tag);
  endtask

  task automatic send_b(input logic [31:0] x, input logic [31:0] y, output int hs);
    int w = 0;
    in_valid_b = 1'b1;
    in_x_b = x;
    in_y_b = y;
    while (1) begin
      @(negedge clk);
      if (in_ready_b) break;
      w++;
      if (w > 200) begin
        check("b_ready_timeout", 0, 1);
        break;
      end
    end
    hs = cyc;
    @(posedge clk);
    #1 in_valid_b = 1'b0;
  endtask

  task automatic job_b(input string tag);
    int h0, h1, w;
    send_b(32'h0000_FFFF, 32'h0000_0000, h0);
    send_b(32'hFFFF_FF12, 32'h0000_0012, h1);
    w = 0;
    while (1) begin
      @(negedge clk);
      if (res_valid_b) break;
      w++;
      if (w > 200) begin
        check({tag, "_timeout"}, 0, 1);
        break;
      end
    end
    check({tag, "_latency"}, cyc - h0, NB + 2);
    check({tag, "_data"}, res_data_b, 16);
    @(posedge clk);
    #1;
    @(negedge clk);
    check({tag, "_released"}, busy_b, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hs;
    logic [31:0] x, y;
    rst = 1'b1;
    in_valid = 1'b0;
    in_x = '0;
    in_y = '0;
    res_ready = 1'b1;
    in_valid_b = 1'b0;
    in_x_b = '0;
    in_y_b = '0;
    res_ready_b = 1'b1;
`ifdef HAMMING_SEQ_THRESH_EN
    thresh = OW'(N);
    thresh_b = OWB'(16);
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", in_ready, 1);
    check("reset_acc_rst", acc_rst, 1);
    check("reset_acc_xy", {acc_x, acc_y}, 0);
    check("reset_res_valid", res_valid, 0);
    check("reset_res_data", res_data, 0);
    check("reset_busy", busy, 0);
`ifdef HAMMING_SEQ_THRESH_EN
    check("reset_res_match", res_match, 0);
`endif
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    run_job(1, -1, N + 2, 1600, "t1_all_diff");
    run_job(2, -1, N + 2, 0, "t2_equal");
    run_job(3, 10, N + 7, 1600, "t3_stall");

    // Result held while the consumer is not ready.
    res_ready = 1'b0;
    run_job(3, -1, N + 2, 1600, "t4_hold");
    repeat (20) begin
      @(negedge clk);
      check("t4_hold_valid", res_valid, 1);
      check("t4_hold_data", res_data, 1600);
      check("t4_hold_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1 res_ready = 1'b1;
    @(negedge clk);
    check("t4_last_valid", res_valid, 1);
    @(negedge clk);
    check("t4_idle_busy", busy, 0);
    check("t4_idle_valid", res_valid, 0);
    check("t4_idle_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Abort part-way through a job, then run a fresh job.
    for (int k = 0; k < 22; k++) begin
      pattern(1, k, x, y);
      send_chunk(x, y, hs);
    end
    repeat (28) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("t5_rst_acc_rst", acc_rst, 1);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_valid", res_valid, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (40) @(negedge clk);
    check("t5_quiet_valid", res_valid, 0);
    check("t5_quiet_acc_rst", acc_rst, 1);
    @(posedge clk);
    #1;
    run_job(5, -1, N + 2, 50, "t5_one_bit");

    job_b("t6_short");
`ifdef HAMMING_SEQ_THRESH_EN
    check("t6_match_16", res_match_b, 1);
    thresh_b = OWB'(15);
    job_b("t6_short_th15");
    check("t6_match_15", res_match_b, 0);
`endif

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
